// File: rtl/word_serial_pkg.sv
// Shared types and width helpers for the word-framed serial transmitter.
package word_serial_pkg;

  typedef enum logic [1:0] {ST_LOAD, ST_SEND, ST_GAP} state_e;

  // Counter width for a count of n states, kept at least 1 bit wide.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int byte_cnt_w(input int data_w);
    return $clog2(data_w / 8) + 1;
  endfunction

  function automatic int half_period(input int bit_div);
    return bit_div / 2;
  endfunction

endpackage

// File: rtl/sertx_bit_timer.sv
// Bit-period divider with bit-index and gap-bit counters for word_serial_tx.
module sertx_bit_timer
  import word_serial_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int BIT_DIV  = 4,
  parameter int GAP_BITS = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        send_i,
  input  logic                        gap_i,
  output logic                        bit_tick_o,
  output logic                        last_bit_o,
  output logic                        gap_done_o,
  output logic                        half_nxt_o,
  output logic [cnt_w(DATA_W)-1:0]    idx_nxt_o
);

  localparam int DIV_W = cnt_w(BIT_DIV);
  localparam int IDX_W = cnt_w(DATA_W);
  localparam int GAP_W = cnt_w(GAP_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(half_period(BIT_DIV));
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  logic [DIV_W-1:0] div_q, div_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  assign bit_tick_o = (div_q == DIV_LAST);
  assign last_bit_o = send_i && (idx_q == IDX_LAST);
  assign gap_done_o = gap_i && (gap_q == GAP_LAST);

  always_comb begin
    div_d = '0;
    idx_d = '0;
    gap_d = '0;
    if (send_i || gap_i) div_d = bit_tick_o ? '0 : div_q + 1'b1;
    if (send_i) idx_d = bit_tick_o ? ((idx_q == IDX_LAST) ? '0 : idx_q + 1'b1) : idx_q;
    if (gap_i) gap_d = bit_tick_o ? ((gap_q == GAP_LAST) ? '0 : gap_q + 1'b1) : gap_q;
  end

  // Outputs are registered in the top, so it needs the next cycle's phase and index.
  assign half_nxt_o = (div_d >= DIV_HALF);
  assign idx_nxt_o  = idx_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q <= '0;
      idx_q <= '0;
      gap_q <= '0;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
      gap_q <= gap_d;
    end
  end

endmodule

// File: rtl/word_serial_tx.sv
// Byte-loaded word serialiser: assembles DATA_W/8 bytes, shifts LSB first with bit clock and frame.
module word_serial_tx
  import word_serial_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int BIT_DIV  = 4,
  parameter int GAP_BITS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       ser_data,
  output logic       ser_clk,
  output logic       ser_frame,
  output logic       busy,
  output logic       word_done
);

  localparam int NB    = DATA_W / 8;
  localparam int CNT_W = byte_cnt_w(DATA_W);
  localparam int IDX_W = cnt_w(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NB - 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [DATA_W-1:0]  word_q, word_d;
  logic               in_ready_q, ser_data_q, ser_clk_q, ser_frame_q, busy_q, word_done_q;
  logic               hs, bit_tick, last_bit, gap_done, half_nxt;
  logic [IDX_W-1:0]   idx_nxt;

  assign hs = in_valid && in_ready_q;

  sertx_bit_timer #(
    .DATA_W   (DATA_W),
    .BIT_DIV  (BIT_DIV),
    .GAP_BITS (GAP_BITS)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .send_i     (state_q == ST_SEND),
    .gap_i      (state_q == ST_GAP),
    .bit_tick_o (bit_tick),
    .last_bit_o (last_bit),
    .gap_done_o (gap_done),
    .half_nxt_o (half_nxt),
    .idx_nxt_o  (idx_nxt)
  );

  always_comb begin
    word_d = word_q;
    for (int k = 0; k < NB; k++) begin
      if (hs && (cnt_q == CNT_W'(k))) word_d[8*k +: 8] = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_LOAD;
      cnt_q       <= '0;
      word_q      <= '0;
      in_ready_q  <= 1'b0;
      ser_data_q  <= 1'b0;
      ser_clk_q   <= 1'b0;
      ser_frame_q <= 1'b0;
      busy_q      <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      word_q      <= word_d;
      word_done_q <= 1'b0;
      case (state_q)
        ST_LOAD: begin
          in_ready_q <= 1'b1;
          if (hs) begin
            if (cnt_q == CNT_LAST) begin
              // Last byte: bit 0 goes out on the very next cycle.
              cnt_q       <= '0;
              state_q     <= ST_SEND;
              in_ready_q  <= 1'b0;
              ser_data_q  <= word_d[0];
              ser_clk_q   <= 1'b0;
              ser_frame_q <= 1'b1;
              busy_q      <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ST_SEND: begin
          if (bit_tick && last_bit) begin
            ser_data_q  <= 1'b0;
            ser_clk_q   <= 1'b0;
            ser_frame_q <= 1'b0;
            word_done_q <= 1'b1;
            if (GAP_BITS == 0) begin
              state_q    <= ST_LOAD;
              busy_q     <= 1'b0;
              in_ready_q <= 1'b1;
            end else begin
              state_q <= ST_GAP;
            end
          end else begin
            ser_data_q <= word_q[idx_nxt];
            ser_clk_q  <= half_nxt;
          end
        end
        ST_GAP: begin
          if (bit_tick && gap_done) begin
            state_q    <= ST_LOAD;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b1;
          end
        end
        default: state_q <= ST_LOAD;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign ser_data  = ser_data_q;
  assign ser_clk   = ser_clk_q;
  assign ser_frame = ser_frame_q;
  assign busy      = busy_q;
  assign word_done = word_done_q;

endmodule
